fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the five-stage pipeline: owns the PC register, drives the instruction-memory request, and loads the IF/ID pipeline register. It consumes the control outputs of the hazard unit (pc_en, stall_ifid, flush_ifid) together with the resolved branch redirect. It guarantees that no wrong-path instruction enters IF/ID, including when a redirect arrives while an instruction-memory access is still outstanding.

## Interface

- PC_RESET, 32'h0000_0000, PC value loaded on reset
- CLK  in  1  pipeline clock, all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- imemREN  out  1  instruction read request
- imemaddr  out  32  instruction address; held stable until ihit
- ihit  in  1  instruction memory returns imemload this cycle
- imemload  in  32  fetched instruction word
- pc_en  in  1  hazard unit: allow sequential PC advance
- stall_ifid  in  1  hazard unit: hold IF/ID contents
- flush_ifid  in  1  hazard unit: load bubble into IF/ID
- branch  in  1  taken branch/jump resolved this cycle
- branch_target  in  32  redirect address, valid with branch
- halt  in  1  halt instruction committed
- instr_id  out  32  IF/ID instruction
- pc_id  out  32  IF/ID fetch address
- npc_id  out  32  IF/ID pc+4
- valid_id  out  1  IF/ID holds a real instruction
- fetch_state  out  2  current FSM state (debug)

## Operation

- States: RUN, DRAIN, HALT. Reset state RUN.
- imemaddr = PC in RUN and DRAIN; imemREN = 1 in RUN and DRAIN, 0 in HALT.
- RUN, no branch:
  - ihit & pc_en & !stall_ifid: IF/ID <= {imemload, PC, PC+4, valid=1}; PC <= PC+4.
  - Otherwise PC holds. IF/ID holds if stall_ifid, else loads a bubble.
- RUN, branch & ihit: PC <= {branch_target[31:2], 2'b00}; the fetched word is discarded.
- RUN, branch & !ihit: redirect_pc <= target (low bits zeroed); go to DRAIN. The address stays on imemaddr because memory requires address stability until ihit.
- DRAIN: imemaddr holds old PC.
  - On ihit: discard the word, PC <= redirect_pc, go to RUN.
  - A new branch in DRAIN overwrites redirect_pc (youngest wins).
  - IF/ID never receives a valid instruction in DRAIN.
- Branch overrides pc_en=0. The hazard unit deasserts pc_en on branch, and that blocks only sequential advance.
- halt: go to HALT from any state, PC frozen, IF/ID bubble. Only RST exits HALT.
- Priorities: halt > branch > flush_ifid > stall_ifid > normal load.
- Bubble = instr_id 32'h0 (nop), valid_id 0, pc_id/npc_id 0.
- PC+4 wraps modulo 2^32. 32'hFFFF_FFFC + 4 = 0.

## Timing

- Reset values: PC = PC_RESET, fetch_state = RUN, imemREN = 1 (combinational from state), imemaddr = PC_RESET, instr_id = 0, pc_id = 0, npc_id = 0, valid_id = 0, redirect_pc = 0.
- RST asserted mid-DRAIN abandons the pending redirect. The first request after release is PC_RESET.
- Fetch latency: an instruction with ihit in cycle N is visible on instr_id in cycle N+1.
- Redirect with ihit in cycle N: imemaddr = target in cycle N+1.
- Redirect without ihit: target is presented the cycle after the outstanding ihit.
- imemaddr changes only on the clock after ihit, a redirect with ihit, or reset.

## Structure

- cpu_types_pkg (shared) holds:
  - word_t (32-bit)
  - fetch_state_t enum {RUN, DRAIN, HALT}
  - constant NOP_INSTR = 32'h0
- Sub-module ifid_reg: the IF/ID register with flush/stall/bubble priority. The ID stage reuses it.
- fetch_unit contains the PC register, redirect_pc, and the FSM.

## Test plan

- Reset release, ihit always 1, no hazards: imemaddr 0, 4, 8, 12 on consecutive cycles; valid_id rises one cycle after the first hit with instr_id = word at 0.
- ihit low 3 cycles at PC 0x10: imemaddr holds 0x10; IF/ID holds bubbles; PC advances to 0x14 only after the hit.
- branch = 1, target 0x40 with ihit = 1 at PC 0x20: next imemaddr 0x40; word from 0x20 never has valid_id = 1.
- branch target 0x80 with ihit = 0:
  - fetch_state = DRAIN; imemaddr stays 0x24 until ihit.
  - Then imemaddr becomes 0x80 and the 0x24 word is dropped.
  - A second branch to 0x90 during DRAIN yields 0x90.
- Simultaneous stall_ifid + flush_ifid: bubble loaded. stall_ifid alone with ihit: IF/ID and PC unchanged.
- halt in DRAIN: imemREN = 0 and state HALT on the next cycle. RST asserted asynchronously: PC = PC_RESET and state = RUN immediately.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, fetch FSM states, NOP encoding and word alignment helper.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam word_t NOP_INSTR = 32'h0000_0000;

    // Instruction addresses are word aligned; drop the byte offset.
    function automatic word_t align_word(input word_t a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Priority: flush (bubble) > stall (hold) > load > bubble.
module ifid_reg
    import cpu_types_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  flush_i,
    input  logic  stall_i,
    input  logic  load_i,
    input  word_t instr_i,
    input  word_t pc_i,
    input  word_t npc_i,
    output word_t instr_o,
    output word_t pc_o,
    output word_t npc_o,
    output logic  valid_o
);

    word_t instr_q, instr_d;
    word_t pc_q, pc_d;
    word_t npc_q, npc_d;
    logic  valid_q, valid_d;

    // Select next contents: bubble by default, hold on stall, capture on load.
    always_comb begin
        instr_d = NOP_INSTR;
        pc_d    = '0;
        npc_d   = '0;
        valid_d = 1'b0;
        if (flush_i) begin
            instr_d = NOP_INSTR;
        end else if (stall_i) begin
            instr_d = instr_q;
            pc_d    = pc_q;
            npc_d   = npc_q;
            valid_d = valid_q;
        end else if (load_i) begin
            instr_d = instr_i;
            pc_d    = pc_i;
            npc_d   = npc_i;
            valid_d = 1'b1;
        end
    end

    // Register update with asynchronous reset to a bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign npc_o   = npc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, pending redirect and RUN/DRAIN/HALT FSM
// feeding the IF/ID register. A redirect that arrives while a fetch is still
// outstanding is parked in redirect_pc until the memory returns (DRAIN).
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_RESET = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        pc_en,
    input  logic        stall_ifid,
    input  logic        flush_ifid,
    input  logic        branch,
    input  logic [31:0] branch_target,
    input  logic        halt,
    output logic [31:0] instr_id,
    output logic [31:0] pc_id,
    output logic [31:0] npc_id,
    output logic        valid_id,
    output logic [1:0]  fetch_state
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        redirect_q, redirect_d;
    logic         ifid_flush;
    logic         ifid_load;
    word_t        pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    // Next-state, next-PC and IF/ID control; halt > branch > flush > stall > load.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redirect_d = redirect_q;
        ifid_flush = flush_ifid;
        ifid_load  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (halt) begin
                    state_d    = HALT;
                    ifid_flush = 1'b1;
                end else if (branch) begin
                    ifid_flush = 1'b1;
                    if (ihit) begin
                        pc_d = align_word(branch_target);
                    end else begin
                        redirect_d = align_word(branch_target);
                        state_d    = DRAIN;
                    end
                end else if (ihit && pc_en && !stall_ifid && !flush_ifid) begin
                    ifid_load = 1'b1;
                    pc_d      = pc_plus4;
                end
            end
            DRAIN: begin
                if (halt) begin
                    state_d    = HALT;
                    ifid_flush = 1'b1;
                end else begin
                    // The word returned here is wrong-path; a branch seen in
                    // the same cycle is younger than the parked redirect.
                    if (branch) begin
                        ifid_flush = 1'b1;
                    end
                    if (ihit) begin
                        state_d = RUN;
                        pc_d    = branch ? align_word(branch_target) : redirect_q;
                    end else if (branch) begin
                        redirect_d = align_word(branch_target);
                    end
                end
            end
            HALT: begin
                ifid_flush = 1'b1;
            end
            default: begin
                state_d    = RUN;
                ifid_flush = 1'b1;
            end
        endcase
    end

    // State, PC and pending redirect registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= RUN;
            pc_q       <= PC_RESET;
            redirect_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
        end
    end

    assign imemaddr    = pc_q;
    assign imemREN     = (state_q != HALT);
    assign fetch_state = state_q;

    ifid_reg u_ifid (
        .clk_i   (CLK),
        .rst_i   (RST),
        .flush_i (ifid_flush),
        .stall_i (stall_ifid),
        .load_i  (ifid_load),
        .instr_i (imemload),
        .pc_i    (pc_q),
        .npc_i   (pc_plus4),
        .instr_o (instr_id),
        .pc_o    (pc_id),
        .npc_o   (npc_id),
        .valid_o (valid_id)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural fetch model.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        pc_en;
    logic        stall_ifid;
    logic        flush_ifid;
    logic        branch;
    logic [31:0] branch_target;
    logic        halt;
    logic [31:0] instr_id;
    logic [31:0] pc_id;
    logic [31:0] npc_id;
    logic        valid_id;
    logic [1:0]  fetch_state;

    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_halted;
    bit          m_pend;
    logic [31:0] m_redir;
    logic [31:0] m_instr, m_pcid, m_npcid;
    bit          m_valid;

    fetch_unit #(.PC_RESET(32'h0000_0000)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .imemREN       (imemREN),
        .imemaddr      (imemaddr),
        .ihit          (ihit),
        .imemload      (imemload),
        .pc_en         (pc_en),
        .stall_ifid    (stall_ifid),
        .flush_ifid    (flush_ifid),
        .branch        (branch),
        .branch_target (branch_target),
        .halt          (halt),
        .instr_id      (instr_id),
        .pc_id         (pc_id),
        .npc_id        (npc_id),
        .valid_id      (valid_id),
        .fetch_state   (fetch_state)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    task automatic model_reset();
        m_pc     = 32'h0;
        m_halted = 0;
        m_pend   = 0;
        m_redir  = 32'h0;
        m_instr  = 32'h0;
        m_pcid   = 32'h0;
        m_npcid  = 32'h0;
        m_valid  = 0;
    endtask

    task automatic model_bubble();
        m_instr = 32'h0;
        m_pcid  = 32'h0;
        m_npcid = 32'h0;
        m_valid = 0;
    endtask

    task automatic check_outputs();
        logic [31:0] exp_state;
        exp_state = m_halted ? 32'd2 : (m_pend ? 32'd1 : 32'd0);
        check("imemaddr", imemaddr, m_pc);
        check("imemREN", {31'b0, imemREN}, {31'b0, !m_halted});
        check("fetch_state", {30'b0, fetch_state}, exp_state);
        check("instr_id", instr_id, m_instr);
        check("pc_id", pc_id, m_pcid);
        check("npc_id", npc_id, m_npcid);
        check("valid_id", {31'b0, valid_id}, {31'b0, m_valid});
    endtask

    // One clock: check current outputs, apply inputs, advance model, wait a cycle.
    task automatic step(input bit ih, input bit pe, input bit st, input bit fl,
                        input bit br, input logic [31:0] tgt, input bit hl);
        logic [31:0] atgt;
        logic [31:0] word;
        check_outputs();
        word          = mem_word(m_pc);
        ihit          = ih;
        imemload      = ih ? word : $urandom;
        pc_en         = pe;
        stall_ifid    = st;
        flush_ifid    = fl;
        branch        = br;
        branch_target = tgt;
        halt          = hl;
        atgt          = tgt & 32'hFFFF_FFFC;
        if (m_halted) begin
            model_bubble();
        end else if (hl) begin
            m_halted = 1;
            model_bubble();
        end else if (m_pend) begin
            // Waiting for the stale fetch: nothing new may enter IF/ID.
            if (!(st && !fl && !br)) model_bubble();
            if (ih) begin
                m_pc   = br ? atgt : m_redir;
                m_pend = 0;
            end else if (br) begin
                m_redir = atgt;
            end
        end else if (br) begin
            model_bubble();
            if (ih) m_pc = atgt;
            else begin
                m_pend  = 1;
                m_redir = atgt;
            end
        end else if (fl) begin
            model_bubble();
        end else if (st) begin
            // hold
        end else if (ih && pe) begin
            m_instr = word;
            m_pcid  = m_pc;
            m_npcid = m_pc + 32'd4;
            m_valid = 1;
            m_pc    = m_pc + 32'd4;
        end else begin
            model_bubble();
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Reset asserted off the clock edge; outputs must respond immediately.
    task automatic do_reset();
        #3;
        RST = 1'b1;
        ihit = 0; pc_en = 0; stall_ifid = 0; flush_ifid = 0;
        branch = 0; branch_target = 0; halt = 0; imemload = 0;
        #1;
        model_reset();
        check("rst_imemaddr", imemaddr, 32'h0);
        check("rst_state", {30'b0, fetch_state}, 32'd0);
        check("rst_imemREN", {31'b0, imemREN}, 32'd1);
        check("rst_valid", {31'b0, valid_id}, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        ihit = 0; pc_en = 0; stall_ifid = 0; flush_ifid = 0;
        branch = 0; branch_target = 0; halt = 0; imemload = 0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Sequential fetch 0,4,8,12
        repeat (4) step(1, 1, 0, 0, 0, 0, 0);
        // Miss for 3 cycles at 0x10, then hit
        repeat (3) step(0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0, 0, 0, 0);
        // PC = 0x20: branch to 0x40 with hit, pc_en low
        step(1, 0, 0, 0, 1, 32'h40, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        // Back to 0x20, fetch it, then branch to 0x80 while 0x24 misses
        step(1, 0, 0, 0, 1, 32'h23, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h80, 0);
        repeat (2) step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h90, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        // stall+flush together, then stall alone with hit
        step(1, 1, 1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0);
        // Wrap past the top of the address space
        step(1, 0, 0, 0, 1, 32'hFFFF_FFF9, 0);
        repeat (3) step(1, 1, 0, 0, 0, 0, 0);
        // Halt during DRAIN, then async reset
        step(0, 0, 0, 0, 1, 32'h100, 0);
        step(0, 1, 0, 0, 0, 0, 1);
        repeat (3) step(1, 1, 0, 0, 1, 32'h200, 0);
        do_reset();
        step(1, 1, 0, 0, 0, 0, 0);
        // Reset mid-DRAIN drops the parked redirect
        step(0, 0, 0, 0, 1, 32'h300, 0);
        do_reset();
        repeat (2) step(1, 1, 0, 0, 0, 0, 0);

        // Randomized traffic with periodic resets
        for (int seg = 0; seg < 8; seg++) begin
            for (int c = 0; c < 250; c++) begin
                logic [31:0] tgt;
                tgt = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | {28'b0, 4'($urandom)}) : $urandom;
                step($urandom_range(99) < 70, $urandom_range(99) < 85,
                     $urandom_range(99) < 15, $urandom_range(99) < 10,
                     $urandom_range(99) < 10, tgt, $urandom_range(399) == 0);
            end
            do_reset();
        end
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
